// File: rtl/dram_line_master.sv
// AXI4 master that turns cache line-fill reads and write-throughs into
// single-outstanding AXI transactions with a one-cycle completion pulse.
module dram_line_master #(
  parameter logic [3:0]  MASTER_ID  = 4'd0,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_wdata,
  input  logic [3:0]                 req_wstrb,
  output logic                       resp_valid,
  output logic [32*LINE_WORDS-1:0]   resp_rdata,
  output logic                       resp_err,
  output logic [3:0]                 ARID,
  output logic [31:0]                ARADDR,
  output logic [3:0]                 ARLEN,
  output logic [2:0]                 ARSIZE,
  output logic [1:0]                 ARBURST,
  output logic                       ARVALID,
  input  logic                       ARREADY,
  input  logic [3:0]                 RID,
  input  logic [31:0]                RDATA,
  input  logic [1:0]                 RRESP,
  input  logic                       RLAST,
  input  logic                       RVALID,
  output logic                       RREADY,
  output logic [3:0]                 AWID,
  output logic [31:0]                AWADDR,
  output logic [3:0]                 AWLEN,
  output logic [2:0]                 AWSIZE,
  output logic [1:0]                 AWBURST,
  output logic                       AWVALID,
  input  logic                       AWREADY,
  output logic [31:0]                WDATA,
  output logic [3:0]                 WSTRB,
  output logic                       WLAST,
  output logic                       WVALID,
  input  logic                       WREADY,
  input  logic [3:0]                 BID,
  input  logic [1:0]                 BRESP,
  input  logic                       BVALID,
  output logic                       BREADY
);

  localparam int unsigned IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned OFF_W = $clog2(LINE_WORDS * 4);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_ADDR = 3'd3;
  localparam logic [2:0] S_WR_DATA = 3'd4;
  localparam logic [2:0] S_WR_RESP = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]                   state;
  logic [2:0]                   state_nxt;
  logic [31:2]                  addr_q;
  logic [31:0]                  wdata_q;
  logic [3:0]                   wstrb_q;
  logic                         err_q;
  logic [LINE_WORDS-1:0][31:0]  line_q;
  logic [CNT_W-1:0]             beat_cnt;

  logic accept;
  logic r_beat;
  logic r_fill;
  logic r_last_word;
  logic b_beat;
  logic addr_lsb_unused;

  // Byte offset within a word is irrelevant: both bursts are word aligned.
  assign addr_lsb_unused = ^req_addr[1:0];

  assign accept      = (state == S_IDLE) && req_valid;
  assign r_beat      = (state == S_RD_DATA) && RVALID;
  assign r_fill      = beat_cnt < CNT_W'(LINE_WORDS);
  assign r_last_word = beat_cnt == CNT_W'(LINE_WORDS - 1);
  assign b_beat      = (state == S_WR_RESP) && BVALID;

  assign ARID    = MASTER_ID;
  assign ARADDR  = {addr_q[31:OFF_W], OFF_W'(0)};
  assign ARLEN   = 4'(LINE_WORDS - 1);
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign AWID    = MASTER_ID;
  assign AWADDR  = {addr_q, 2'b00};
  assign AWLEN   = 4'd0;
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign WLAST   = 1'b1;

  assign resp_rdata = line_q;
  assign resp_err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next state and per-state handshake outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    ARVALID    = 1'b0;
    RREADY     = 1'b0;
    AWVALID    = 1'b0;
    WVALID     = 1'b0;
    BREADY     = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_write ? S_WR_ADDR : S_RD_ADDR;
      end
      S_RD_ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        RREADY = 1'b1;
        if (RVALID && RLAST) state_nxt = S_DONE;
      end
      S_WR_ADDR: begin
        AWVALID = 1'b1;
        if (AWREADY) state_nxt = S_WR_DATA;
      end
      S_WR_DATA: begin
        WVALID = 1'b1;
        if (WREADY) state_nxt = S_WR_RESP;
      end
      S_WR_RESP: begin
        BREADY = 1'b1;
        if (BVALID) state_nxt = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture, line fill and error accumulation; beats past the line are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      err_q    <= 1'b0;
      line_q   <= '0;
      beat_cnt <= '0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr[31:2];
        wdata_q  <= req_wdata;
        wstrb_q  <= req_wstrb;
        err_q    <= 1'b0;
        line_q   <= '0;
        beat_cnt <= '0;
      end
      if (r_beat && r_fill) begin
        line_q[beat_cnt[IDX_W-1:0]] <= RDATA;
        beat_cnt <= beat_cnt + CNT_W'(1);
        if ((RRESP != 2'b00) || (RID != MASTER_ID) || (RLAST != r_last_word))
          err_q <= 1'b1;
      end
      if (b_beat && ((BRESP != 2'b00) || (BID != MASTER_ID)))
        err_q <= 1'b1;
    end
  end

endmodule

// File: doc/dram_line_master.md
Name: dram_line_master

Overview:
- AXI4 master that turns L1 cache miss/write-through requests into bus transactions toward the DRAM slave port through the interconnect.
- Read misses become one INCR burst that fills a full cache line; write-throughs become single-beat writes with byte strobes.
- One outstanding transaction at a time; the cache side sees a simple valid/ready request and a one-cycle response pulse.

Parameters:
- MASTER_ID, 4'd0, value driven on ARID/AWID and expected on RID/BID.
- LINE_WORDS, 4, 32-bit words per line; power of 2, range 2..16; read burst length = LINE_WORDS.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  1  cache request valid
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = write-through, 0 = line read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_wstrb  in  4  write byte enables, active high
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32*LINE_WORDS  filled line; word i at bits [32i+31:32i]
- resp_err  out  1  completion carried an error; valid with resp_valid
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  4/32/4/3/2/1  read address channel
- ARREADY  in  1
- RID/RDATA/RRESP/RLAST/RVALID  in  4/32/2/1/1  read data channel
- RREADY  out  1
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  4/32/4/3/2/1  write address channel
- AWREADY  in  1
- WDATA/WSTRB/WLAST/WVALID  out  32/4/1/1  write data channel
- WREADY  in  1
- BID/BRESP/BVALID  in  4/2/1  write response channel
- BREADY  out  1

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE.
- Reset (async, rst=0): state IDLE; all VALID/READY outputs 0 except req_ready; resp_valid 0, resp_err 0, resp_rdata 0, beat counter 0.
- req_ready = (state==IDLE), combinational, so it is 1 out of reset.
- Request accepted on req_valid & req_ready; address, data, strobe and type are registered; the error flag and line buffer are cleared.
- IDLE -> RD_ADDR (req_write=0) or WR_ADDR (req_write=1). The VALID output rises on the cycle after acceptance.
- RD_ADDR:
  - ARVALID=1.
  - ARADDR = req_addr with its low log2(LINE_WORDS*4) bits zeroed.
  - ARLEN = LINE_WORDS-1, ARSIZE = 3'b010, ARBURST = 2'b01 (INCR), ARID = MASTER_ID.
  - All AR signals are held stable until ARREADY; on the handshake go to RD_DATA.
- RD_DATA:
  - RREADY=1; each RVALID beat writes RDATA into word beat_cnt, then beat_cnt increments.
  - Set err if RRESP != 2'b00 or RID != MASTER_ID.
  - RLAST on beat LINE_WORDS-1: go to DONE.
  - RLAST on an earlier beat: set err, go to DONE; unfilled words stay 0.
  - Beat LINE_WORDS-1 without RLAST: set err, stay in RD_DATA and discard further beats until RLAST, then go to DONE.
- WR_ADDR:
  - AWVALID=1; AWADDR = req_addr with bits [1:0] zeroed.
  - AWLEN=0, AWSIZE=3'b010, AWBURST=2'b01, AWID=MASTER_ID.
  - Held stable until AWREADY; then go to WR_DATA.
- WR_DATA: WVALID=1, WDATA=req_wdata, WSTRB=req_wstrb, WLAST=1; held until WREADY; then go to WR_RESP. WVALID is never asserted before the AW handshake. WSTRB=0 is still issued.
- WR_RESP: BREADY=1. On BVALID, set err if BRESP != 2'b00 or BID != MASTER_ID; go to DONE.
- DONE:
  - resp_valid=1 for exactly one cycle; resp_err reflects the accumulated error flag.
  - resp_rdata holds the line, and stays stable until the next request is accepted.
  - Next state is IDLE.
- Latency with zero-wait slave:
  - read: acceptance at cycle 0, ARVALID at cycle 1, resp_valid one cycle after the RLAST handshake;
  - write: resp_valid one cycle after the B handshake.
- Input VALIDs are ignored in states that do not own the channel (RVALID outside RD_DATA, BVALID outside WR_RESP). No READY is asserted there.
- Back-to-back requests: the earliest acceptance is on the cycle DONE returns to IDLE.
- Reset mid-transaction: immediate return to IDLE with all VALIDs low; the in-flight bus transaction is abandoned and no resp_valid is generated.

Test Plan:
- Read, LINE_WORDS=4, req_addr=0x0000_1234; slave returns 0xA0..0xA3 with the last beat flagged RLAST -> ARADDR=0x0000_1230, ARLEN=3, ARSIZE=2, ARBURST=1; resp_rdata={0xA3,0xA2,0xA1,0xA0}; resp_err=0; resp_valid high exactly 1 cycle.
- Write, req_addr=0x0000_2006, wdata=0xDEADBEEF, wstrb=4'b0011, AWREADY delayed 5 cycles -> AWADDR=0x0000_2004 held stable for 5 cycles; WVALID=0 until the AW handshake; WLAST=1; BRESP=0 gives resp_err=0.
- Read with RLAST on beat 1 -> resp_err=1; words 2 and 3 = 0; state returns to IDLE.
- Read with RRESP=2'b10 on beat 2, or RID=4'd5 -> resp_err=1; all 4 words still captured.
- rst pulled low while in RD_DATA after 2 beats -> ARVALID/RREADY/resp_valid=0 immediately; req_ready=1 after release; a fresh read then completes correctly.
- Two back-to-back requests (read then write) with req_valid held high -> second request is accepted the cycle after the first resp_valid pulse; no channel overlap.
